mem_sram_dpi: RTL and testbench

//  Sequential, handshaked successor to the combinational DPI memory. Serves one

---
 rtl/mem_pkg.sv | 68 ++++++
 rtl/mem_delay_lfsr.sv | 26 ++
 rtl/mem_sram_dpi.sv | 163 ++++++++++++++++
 tb/tb_mem_sram_dpi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the sequential pmem-backed memories: FSM states,
// delay LFSR constants and the pmem access functions.
package mem_pkg;

    // Request FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Latched request payload (address kept separately, its width is a parameter)
    typedef struct packed {
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    localparam int unsigned LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3
    localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

    // One Fibonacci step: shift left, feed parity of the tapped bits into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // Byte-addressed physical memory image and access counters. pmem_read and
    // pmem_write keep the C-side pmem signatures (32-bit address, 8-lane mask)
    // so callers are unchanged when the image lives outside the simulator.
    logic [7:0]  pmem_bytes [logic [31:0]];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;

    // Word read; bytes never written read as zero
    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        logic [31:0] data;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            if (pmem_bytes.exists(addr + 32'(i))) begin
                data[8*i +: 8] = pmem_bytes[addr + 32'(i)];
            end
        end
        pmem_rd_calls = pmem_rd_calls + 1;
        return data;
    endfunction

    // Byte-lane write; lane i of the 64-bit lane vector goes to addr+i
    function automatic void pmem_write(input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       input logic [7:0]  wmask);
        logic [63:0] lanes;
        lanes = {32'h0, wdata};
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                pmem_bytes[addr + 32'(i)] = lanes[8*i +: 8];
            end
        end
        pmem_wr_calls = pmem_wr_calls + 1;
    endfunction

    // Total number of pmem accesses so far
    function automatic int unsigned pmem_calls();
        return pmem_rd_calls + pmem_wr_calls;
    endfunction

endpackage

// File: rtl/mem_delay_lfsr.sv
// 8-bit Fibonacci LFSR supplying the random part of the access delay.
module mem_delay_lfsr
    import mem_pkg::*;
#(
    parameter int unsigned DLY_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [DLY_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsr_q;

    // Advance once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rnd = lfsr_q[DLY_W-1:0];

endmodule

// File: rtl/mem_sram_dpi.sv
// Handshaked single-outstanding memory with programmable / random access delay,
// backed by the shared pmem image. Misaligned or out-of-window requests get an
// error response without touching memory.
module mem_sram_dpi
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter logic [31:0] SIZE       = 32'h0800_0000,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RAND_DELAY = 0,
    parameter int unsigned DLY_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned        CMP_W   = ADDR_W + 1;
    localparam logic [CMP_W-1:0]   WIN_LO  = CMP_W'(BASE);
    localparam logic [CMP_W-1:0]   WIN_HI  = CMP_W'(BASE) + CMP_W'(SIZE);
    localparam logic [DLY_W:0]     DLY_MAX = {1'b0, {DLY_W{1'b1}}};

    mem_state_e        state_q, state_d;
    logic              req_ready_q;
    mem_req_t          req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DLY_W-1:0]  cnt_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept_c;
    logic              access_c;
    logic              rsp_hs_c;
    logic              addr_ok_c;
    logic [DLY_W-1:0]  rnd_c;
    logic [DLY_W:0]    dly_sum_c;
    logic [DLY_W-1:0]  dly_load_c;

    mem_delay_lfsr #(
        .DLY_W (DLY_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (accept_c),
        .rnd   (rnd_c)
    );

    // Next state and handshake strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        access_c = 1'b0;
        rsp_hs_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept_c = req_valid & req_ready_q;
                if (accept_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                access_c = (cnt_q == '0);
                if (access_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_hs_c = rsp_ready;
                if (rsp_hs_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word alignment and window check on the latched address, one extra bit so BASE+SIZE cannot wrap
    always_comb begin
        addr_ok_c = (addr_q[1:0] == 2'b00)
                 && ({1'b0, addr_q} >= WIN_LO)
                 && ({1'b0, addr_q} <  WIN_HI);
    end

    // Wait-cycle count for a new request, saturating at the counter maximum
    always_comb begin
        dly_sum_c = (DLY_W+1)'(LATENCY);
        if (RAND_DELAY != 0) begin
            dly_sum_c = dly_sum_c + {1'b0, rnd_c};
        end
        dly_load_c = (dly_sum_c > DLY_MAX) ? DLY_MAX[DLY_W-1:0] : dly_sum_c[DLY_W-1:0];
    end

    // State register; req_ready tracks entry into IDLE so it rises one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Request latches, delay counter, memory access and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                req_q.wen   <= req_wen;
                req_q.wdata <= req_wdata;
                req_q.wmask <= req_wmask;
                addr_q      <= req_addr;
                cnt_q       <= dly_load_c;
            end
            if (state_q == ST_WAIT && !access_c) begin
                cnt_q <= cnt_q - DLY_W'(1);
            end
            if (access_c) begin
                rsp_valid_q <= 1'b1;
                if (!addr_ok_c) begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end else if (!req_q.wen) begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= pmem_read(32'(addr_q));
                end else begin
                    if (req_q.wmask != 4'b0000) begin
                        pmem_write(32'(addr_q), req_q.wdata, {4'b0000, req_q.wmask});
                    end
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
            end
            if (rsp_hs_c) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_sram_dpi.sv
// Directed bench for mem_sram_dpi: fixed-latency instance (a) and random-delay instance (b).
module tb_mem_sram_dpi;

    logic        clk;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    logic        sel_b;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int n_checks;
    int n_errors;

    mem_sram_dpi #(
        .ADDR_W(32), .BASE(32'h8000_0000), .SIZE(32'h0800_0000),
        .LATENCY(1), .RAND_DELAY(0), .DLY_W(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    mem_sram_dpi #(
        .ADDR_W(32), .BASE(32'h8000_0000), .SIZE(32'h0800_0000),
        .LATENCY(0), .RAND_DELAY(1), .DLY_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    assign req_ready_m = sel_b ? req_ready_b : req_ready_a;
    assign rsp_valid_m = sel_b ? rsp_valid_b : rsp_valid_a;
    assign rsp_err_m   = sel_b ? rsp_err_b   : rsp_err_a;
    assign rsp_rdata_m = sel_b ? rsp_rdata_b : rsp_rdata_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after the accepting edge, inputs then scrambled
    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        int guard;
        @(negedge clk);
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        if (sel_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        guard = 0;
        while (req_ready_m !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_timeout", 32'(guard < 50), 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_wen     = ~wen;
        req_addr    = addr ^ 32'h0000_0040;
        req_wdata   = ~wdata;
        req_wmask   = ~wmask;
        check("rsp_early", 32'(rsp_valid_m), 32'd0);
    endtask

    // Count edges from accept until rsp_valid is seen
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid_m !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the response handshake and confirm the return to IDLE
    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid_m), 32'd0);
        check("ready_back", 32'(req_ready_m), 32'd1);
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          output logic [31:0] rdata, output logic err, output int lat);
        issue(wen, addr, wdata, wmask);
        wait_rsp(lat);
        rdata = rsp_rdata_m;
        err   = rsp_err_m;
        take_rsp();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int unsigned c0;
        logic [31:0] model [16];
        logic [7:0]  lfsr;
        logic        fb;
        int          lat_min, lat_max, exp_lat;
        logic        wen;
        int          idx;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] addr;

        n_checks    = 0;
        n_errors    = 0;
        sel_b       = 1'b0;
        rst_n       = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_wen     = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wmask   = '0;
        rsp_ready   = 1'b0;

        // Reset values
        #1;
        check("rst_req_ready", 32'(req_ready_a), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_a, 32'd0);
        check("rst_rsp_err", 32'(rsp_err_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_ready", 32'(req_ready_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(req_ready_a), 32'd1);

        // Full-word write then read, latency 2
        c0 = mem_pkg::pmem_calls();
        do_req(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check("t1_wr_err", 32'(er), 32'd0);
        check("t1_wr_rdata", rd, 32'd0);
        check("t1_wr_lat", 32'(lat), 32'd2);
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        check("t1_rd_data", rd, 32'hDEAD_BEEF);
        check("t1_rd_err", 32'(er), 32'd0);
        check("t1_rd_lat", 32'(lat), 32'd2);
        check("t1_calls", mem_pkg::pmem_calls() - c0, 32'd2);

        // Byte-masked write
        do_req(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h8000_0004, 32'h1122_3344, 4'b0101, rd, er, lat);
        check("t2_wr_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lat);
        check("t2_rd_data", rd, 32'hFF22_FF44);

        // Misaligned and out-of-window requests make no access
        c0 = mem_pkg::pmem_calls();
        do_req(1'b0, 32'h8000_0002, 32'h0, 4'h0, rd, er, lat);
        check("t3_mis_err", 32'(er), 32'd1);
        check("t3_mis_rdata", rd, 32'd0);
        do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
        check("t3_low_err", 32'(er), 32'd1);
        check("t3_low_rdata", rd, 32'd0);
        do_req(1'b1, 32'h8800_0000, 32'h1234_5678, 4'hF, rd, er, lat);
        check("t3_top_err", 32'(er), 32'd1);
        check("t3_err_lat", 32'(lat), 32'd2);
        check("t3_no_calls", mem_pkg::pmem_calls() - c0, 32'd0);
        do_req(1'b1, 32'h87FF_FFFC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        check("t3_last_wr_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, rd, er, lat);
        check("t3_last_rd", rd, 32'hCAFE_F00D);
        check("t3_last_err", 32'(er), 32'd0);

        // Empty-mask write: ok response, no access, data untouched
        c0 = mem_pkg::pmem_calls();
        do_req(1'b1, 32'h8000_0000, 32'h1234_5678, 4'h0, rd, er, lat);
        check("t3_m0_err", 32'(er), 32'd0);
        check("t3_m0_calls", mem_pkg::pmem_calls() - c0, 32'd0);
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        check("t3_m0_data", rd, 32'hDEAD_BEEF);

        // Response backpressure: outputs stable, no new request taken
        c0 = mem_pkg::pmem_calls();
        issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
        wait_rsp(lat);
        check("t4_lat", 32'(lat), 32'd2);
        req_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t4_valid", 32'(rsp_valid_a), 32'd1);
            check("t4_rdata", rsp_rdata_a, 32'hFF22_FF44);
            check("t4_ready", 32'(req_ready_a), 32'd0);
        end
        req_valid_a = 1'b0;
        take_rsp();
        check("t4_calls", mem_pkg::pmem_calls() - c0, 32'd1);

        // Reset while a write is waiting drops it
        c0 = mem_pkg::pmem_calls();
        issue(1'b1, 32'h8000_0000, 32'h0000_0000, 4'hF);
        rst_n = 1'b0;
        #1;
        check("t6_req_ready", 32'(req_ready_a), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("t6_rsp_rdata", rsp_rdata_a, 32'd0);
        check("t6_rsp_err", 32'(rsp_err_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_calls", mem_pkg::pmem_calls() - c0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        check("t6_unchanged", rd, 32'hDEAD_BEEF);

        // Random delays against a reference image and LFSR model
        sel_b   = 1'b1;
        lfsr    = 8'hA5;
        lat_min = 100;
        lat_max = 0;
        for (int n = 0; n < 216; n++) begin
            if (n < 16) begin
                wen = 1'b1;
                idx = n;
                wd  = $urandom;
                wm  = 4'hF;
            end else begin
                wen = 1'($urandom_range(0, 1));
                idx = int'($urandom_range(0, 15));
                wd  = $urandom;
                wm  = 4'($urandom_range(0, 15));
            end
            addr    = 32'h8000_1000 + 32'(idx * 4);
            exp_lat = 1 + int'(lfsr[2:0]);
            fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
            lfsr    = {lfsr[6:0], fb};
            c0      = mem_pkg::pmem_calls();
            do_req(wen, addr, wd, wm, rd, er, lat);
            check("t5_lat", 32'(lat), 32'(exp_lat));
            check("t5_err", 32'(er), 32'd0);
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (wm[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                end
                check("t5_wr_rdata", rd, 32'd0);
                check("t5_wr_calls", mem_pkg::pmem_calls() - c0, (wm != 4'h0) ? 32'd1 : 32'd0);
            end else begin
                check("t5_rd_data", rd, model[idx]);
                check("t5_rd_calls", mem_pkg::pmem_calls() - c0, 32'd1);
            end
            if (lat < lat_min) lat_min = lat;
            if (lat > lat_max) lat_max = lat;
        end
        check("t5_lat_min", 32'(lat_min), 32'd1);
        check("t5_lat_max", 32'(lat_max), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
